// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter for the write port of an async FIFO
//            (write-clock domain). Grants whole bursts, ended by req_last or
//            MAX_BURST beats. New bursts are held off while walmostfull is
//            high. Beats in flight are stalled on wfull, so the FIFO is never
//            written while full.
// Options  : FIFO_WR_ARB_STATS_EN - builds the saturating wfull stall counter
//            on stall_cnt. When undefined, stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 8,
    parameter int IDW       = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    input  logic                  walmostfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    // Beat counter only has to reach MAX_BURST-1.
    localparam int c_BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BEAT = c_BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0]   c_LAST_REQ  = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [c_BCW-1:0] r_beat_cnt;
    logic             r_busy;

    logic             w_in_burst;
    logic             w_own_valid;
    logic             w_own_last;
    logic             w_beat;
    logic             w_burst_end;
    logic             w_arb_found;
    logic [IDW-1:0]   w_arb_winner;
    logic [IDW-1:0]   w_next_ptr;

    // Requester index 'off' positions after 'base', wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                                input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Round-robin search: first valid requester starting at r_rr_ptr.
    always_comb begin
        w_arb_found  = 1'b0;
        w_arb_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_arb_found && req_valid[rr_index(r_rr_ptr, k)]) begin
                w_arb_found  = 1'b1;
                w_arb_winner = rr_index(r_rr_ptr, k);
            end
        end
    end

    assign w_in_burst  = (r_state == S_BURST);
    assign w_own_valid = req_valid[r_grant_id];
    assign w_own_last  = req_last[r_grant_id];

    // A beat moves only when the owner offers a word and the FIFO has room.
    assign w_beat      = w_in_burst & w_own_valid & ~wfull;
    assign w_burst_end = w_beat & (w_own_last | (r_beat_cnt == c_LAST_BEAT));
    assign w_next_ptr  = (r_grant_id == c_LAST_REQ) ? '0 : (r_grant_id + 1'b1);

    // Only the current owner sees ready, and only while the FIFO is not full.
    always_comb begin
        req_ready = '0;
        if (w_in_burst && !wfull) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign winc     = w_beat;
    assign wdata    = req_data[r_grant_id*DSIZE +: DSIZE];
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

    // Burst FSM: grant in IDLE, count beats and release the grant in BURST.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // walmostfull only throttles new grants, never a live burst.
                    if (w_arb_found && !walmostfull) begin
                        r_grant_id <= w_arb_winner;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_burst_end) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where the owner had data but the FIFO was full; saturates.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_in_burst && w_own_valid && wfull &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed self-checking bench for fifo_wr_arbiter
//            (NREQ=4, DSIZE=8, MAX_BURST=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int c_NREQ  = 4;
    localparam int c_DSIZE = 8;
    localparam int c_MAXB  = 8;
    localparam int c_IDW   = 2;

    logic                      wclk;
    logic                      wrst_n;
    logic [c_NREQ-1:0]         req_valid;
    logic [c_NREQ*c_DSIZE-1:0] req_data;
    logic [c_NREQ-1:0]         req_last;
    logic [c_NREQ-1:0]         req_ready;
    logic                      wfull;
    logic                      walmostfull;
    logic                      winc;
    logic [c_DSIZE-1:0]        wdata;
    logic [c_IDW-1:0]          grant_id;
    logic                      busy;
    logic [15:0]               stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(
        .NREQ      (c_NREQ),
        .DSIZE     (c_DSIZE),
        .MAX_BURST (c_MAXB),
        .IDW       (c_IDW)
    ) u_dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .wfull       (wfull),
        .walmostfull (walmostfull),
        .winc        (winc),
        .wdata       (wdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        int g;
        wrst_n      = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        wfull       = 1'b0;
        walmostfull = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge wclk);
        #2;
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_winc",  32'(winc), 32'd0);
        check_val("rst_gid",   32'(grant_id), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_stall", 32'(stall_cnt), 32'd0);
        step();
        wrst_n = 1'b1;

        // ---------------- single requester 2, 3-word burst ----------------
        req_valid = 4'b0100;
        req_data[2*8 +: 8] = 8'hA0;
        #1;
        check_val("s1_idle_busy", 32'(busy), 32'd0);
        check_val("s1_idle_winc", 32'(winc), 32'd0);
        step();
        #1;
        check_val("s1_busy",  32'(busy), 32'd1);
        check_val("s1_gid",   32'(grant_id), 32'd2);
        check_val("s1_ready", 32'(req_ready), 32'b0100);
        check_val("s1_winc0", 32'(winc), 32'd1);
        check_val("s1_data0", 32'(wdata), 32'hA0);
        step();
        req_data[2*8 +: 8] = 8'hA1;
        #1;
        check_val("s1_winc1", 32'(winc), 32'd1);
        check_val("s1_data1", 32'(wdata), 32'hA1);
        step();
        req_data[2*8 +: 8] = 8'hA2;
        req_last = 4'b0100;
        #1;
        check_val("s1_winc2", 32'(winc), 32'd1);
        check_val("s1_data2", 32'(wdata), 32'hA2);
        step();
        req_valid = '0;
        req_last  = '0;
        #1;
        check_val("s1_end_busy", 32'(busy), 32'd0);
        check_val("s1_end_winc", 32'(winc), 32'd0);

        // ---------------- all valid, max bursts; rr_ptr=3 so 3,0,1,2,3 -----
        for (int i = 0; i < c_NREQ; i++) begin
            req_data[i*8 +: 8] = 8'(8'hC0 + i);
        end
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            g = (3 + b) % 4;
            #1;
            check_val($sformatf("s2_gap%0d_busy", b), 32'(busy), 32'd0);
            check_val($sformatf("s2_gap%0d_winc", b), 32'(winc), 32'd0);
            step();
            for (int k = 0; k < c_MAXB; k++) begin
                #1;
                check_val($sformatf("s2_b%0d_k%0d_gid", b, k), 32'(grant_id), 32'(g));
                check_val($sformatf("s2_b%0d_k%0d_winc", b, k), 32'(winc), 32'd1);
                check_val($sformatf("s2_b%0d_k%0d_data", b, k), 32'(wdata), 32'(8'hC0 + g));
                step();
            end
        end
        req_valid = '0;
        #1;
        check_val("s2_end_busy", 32'(busy), 32'd0);

        // ---------------- walmostfull throttling ----------------
        step();
        walmostfull = 1'b1;
        req_valid   = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val($sformatf("s3_amf%0d_busy", c), 32'(busy), 32'd0);
            check_val($sformatf("s3_amf%0d_winc", c), 32'(winc), 32'd0);
            step();
        end
        walmostfull = 1'b0;
        step();
        #1;
        check_val("s3_gid",  32'(grant_id), 32'd0);
        check_val("s3_busy", 32'(busy), 32'd1);

        // ---------------- wfull stall after beat 3 ----------------
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("s4_pre%0d_winc", k), 32'(winc), 32'd1);
            step();
            #1;
        end
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val($sformatf("s4_stall%0d_winc", c), 32'(winc), 32'd0);
            check_val($sformatf("s4_stall%0d_ready", c), 32'(req_ready), 32'd0);
            check_val($sformatf("s4_stall%0d_busy", c), 32'(busy), 32'd1);
            step();
        end
        wfull = 1'b0;
        for (int k = 3; k < c_MAXB; k++) begin
            #1;
            check_val($sformatf("s4_post%0d_busy", k), 32'(busy), 32'd1);
            check_val($sformatf("s4_post%0d_winc", k), 32'(winc), 32'd1);
            step();
        end
        req_valid = '0;
        #1;
        check_val("s4_end_busy", 32'(busy), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check_val("s4_stall_cnt", 32'(stall_cnt), 32'd5);
`else
        check_val("s4_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // ---------------- reset mid-burst (rr_ptr=1 -> requester 1) -------
        step();
        req_valid = 4'b0011;
        step();
        #1;
        check_val("s5_gid1", 32'(grant_id), 32'd1);
        step();
        #1;
        check_val("s5_beat2_winc", 32'(winc), 32'd1);
        wrst_n = 1'b0;
        #1;
        check_val("s5_rst_busy",  32'(busy), 32'd0);
        check_val("s5_rst_winc",  32'(winc), 32'd0);
        check_val("s5_rst_gid",   32'(grant_id), 32'd0);
        check_val("s5_rst_ready", 32'(req_ready), 32'd0);
        check_val("s5_rst_stall", 32'(stall_cnt), 32'd0);
        step();
        wrst_n = 1'b1;
        #1;
        check_val("s5_rel_busy", 32'(busy), 32'd0);
        step();
        #1;
        check_val("s5_first_gid",  32'(grant_id), 32'd0);
        check_val("s5_first_busy", 32'(busy), 32'd1);

        // ---------------- owner drops valid mid-burst ----------------
        step();
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val($sformatf("s6_hold%0d_gid", c), 32'(grant_id), 32'd0);
            check_val($sformatf("s6_hold%0d_busy", c), 32'(busy), 32'd1);
            check_val($sformatf("s6_hold%0d_winc", c), 32'(winc), 32'd0);
            check_val($sformatf("s6_hold%0d_ready", c), 32'(req_ready), 32'b0001);
            step();
        end
        req_valid = 4'b0011;
        req_last  = 4'b0001;
        #1;
        check_val("s6_last_winc", 32'(winc), 32'd1);
        check_val("s6_last_data", 32'(wdata), 32'hC0);
        step();
        req_last = '0;
        #1;
        check_val("s6_end_busy", 32'(busy), 32'd0);
        step();
        #1;
        check_val("s6_next_gid",  32'(grant_id), 32'd1);
        check_val("s6_next_busy", 32'(busy), 32'd1);
        req_valid = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
